// File: rtl/madam_mem_arbiter.sv
// Round-robin arbiter sharing the single MADAM memory port among NUM_REQ requesters.
// One memory transaction is outstanding at a time; each requester sees its own gnt/rsp_valid.
module madam_mem_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_REQ*BE_WIDTH-1:0]    be_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic [BE_WIDTH-1:0]            mem_be,
  input  logic                           mem_gnt,
  input  logic                           mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]     owner_o,
  output logic                           busy_o
);

  localparam int unsigned OW = $clog2(NUM_REQ);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StIssue   = 2'd1;
  localparam logic [1:0] StWaitRsp = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic [OW-1:0] pick;
  logic          found;
  int unsigned   idx;
  logic          issue;

  // First requester above the last winner, wrapping around.
  always_comb begin
    pick  = owner_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_q) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          owner_d = pick;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_gnt) begin
          if (mem_rsp_valid) begin
            state_d = StIdle;
            last_d  = owner_q;
          end else begin
            state_d = StWaitRsp;
          end
        end
      end
      StWaitRsp: begin
        if (mem_rsp_valid) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign issue  = (state_q == StIssue);
  assign busy_o = (state_q == StIssue) || (state_q == StWaitRsp);
  assign owner_o = owner_q;
  assign rdata_o = mem_rdata;

  // Payload is forced to zero outside ISSUE so the memory side sees a quiet bus.
  assign mem_req   = issue;
  assign mem_we    = issue ? we_i[owner_q] : 1'b0;
  assign mem_addr  = issue ? addr_i[owner_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_wdata = issue ? wdata_i[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign mem_be    = issue ? be_i[owner_q*BE_WIDTH +: BE_WIDTH] : '0;

  always_comb begin
    gnt_o       = '0;
    rsp_valid_o = '0;
    if (issue) begin
      gnt_o[owner_q] = mem_gnt;
    end
    if (busy_o) begin
      rsp_valid_o[owner_q] = mem_rsp_valid;
    end
  end

endmodule

// File: tb/tb_madam_mem_arbiter.sv
// Directed bench for madam_mem_arbiter: reset, single write, simultaneous requests,
// fairness, split response, reset mid-transaction and back-to-back re-request.
module tb_madam_mem_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = DW / 8;

  logic              clk = 1'b0;
  logic              areset;
  logic [NR-1:0]     req_i;
  logic [NR-1:0]     we_i;
  logic [NR*AW-1:0]  addr_i;
  logic [NR*DW-1:0]  wdata_i;
  logic [NR*BW-1:0]  be_i;
  logic [NR-1:0]     gnt_o;
  logic [NR-1:0]     rsp_valid_o;
  logic [DW-1:0]     rdata_o;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [BW-1:0]     mem_be;
  logic              mem_gnt;
  logic              mem_rsp_valid;
  logic [DW-1:0]     mem_rdata;
  logic [1:0]        owner_o;
  logic              busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int grants [NR];

  always #5 clk = ~clk;

  madam_mem_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BE_WIDTH  (BW)
  ) dut (
    .aclk         (clk),
    .areset       (areset),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .be_i         (be_i),
    .gnt_o        (gnt_o),
    .rsp_valid_o  (rsp_valid_o),
    .rdata_o      (rdata_o),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_gnt      (mem_gnt),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata),
    .owner_o      (owner_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requesters must keep req high for as long as the arbiter is issuing on their behalf.
  always @(posedge clk) begin
    if (!areset && mem_req) check("req_held_in_issue", 64'(req_i[owner_o]), 64'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
    req_i[k]             = 1'b1;
    we_i[k]              = we;
    addr_i[k*AW +: AW]   = a;
    wdata_i[k*DW +: DW]  = d;
    be_i[k*BW +: BW]     = b;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    req_i         = '0;
    we_i          = '0;
    addr_i        = '0;
    wdata_i       = '0;
    be_i          = '0;
    mem_gnt       = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    repeat (2) tick();
    areset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) grants[i] = 0;
    do_reset();
    settle();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_owner", 64'(owner_o), 64'd0);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_rsp", 64'(rsp_valid_o), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);

    // Single write from requester 0; memory answers 2 cycles after mem_req.
    set_req(0, 1'b1, 32'h0020_0000, 32'h0000_a108, 4'h3);
    settle();
    check("w_req_t", 64'(mem_req), 64'd0);
    tick();
    check("w_req_t1", 64'(mem_req), 64'd1);
    check("w_we", 64'(mem_we), 64'd1);
    check("w_addr", 64'(mem_addr), 64'h0020_0000);
    check("w_wdata", 64'(mem_wdata), 64'h0000_a108);
    check("w_be", 64'(mem_be), 64'h3);
    check("w_busy", 64'(busy_o), 64'd1);
    check("w_gnt_wait", 64'(gnt_o), 64'd0);
    tick();
    check("w_req_t2", 64'(mem_req), 64'd1);
    tick();
    mem_gnt = 1'b1;
    mem_rsp_valid = 1'b1;
    settle();
    check("w_gnt", 64'(gnt_o), 64'b001);
    check("w_rsp", 64'(rsp_valid_o), 64'b001);
    tick();
    mem_gnt = 1'b0;
    mem_rsp_valid = 1'b0;
    req_i = '0;
    settle();
    check("w_busy_after", 64'(busy_o), 64'd0);
    check("w_req_after", 64'(mem_req), 64'd0);

    // Simultaneous requests from 0 and 2 after reset: 0 first, then 2.
    do_reset();
    set_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'hf);
    set_req(2, 1'b0, 32'h0000_0300, 32'h0, 4'hf);
    tick();
    check("sim_owner0", 64'(owner_o), 64'd0);
    mem_gnt = 1'b1;
    mem_rsp_valid = 1'b1;
    settle();
    check("sim_gnt0", 64'(gnt_o), 64'b001);
    tick();
    mem_gnt = 1'b0;
    mem_rsp_valid = 1'b0;
    req_i[0] = 1'b0;
    settle();
    check("sim_idle", 64'(busy_o), 64'd0);
    tick();
    check("sim_owner2", 64'(owner_o), 64'd2);
    check("sim_addr2", 64'(mem_addr), 64'h0000_0300);
    mem_gnt = 1'b1;
    mem_rsp_valid = 1'b1;
    settle();
    check("sim_gnt2", 64'(gnt_o), 64'b100);
    check("sim_rsp2", 64'(rsp_valid_o), 64'b100);
    tick();
    mem_gnt = 1'b0;
    mem_rsp_valid = 1'b0;
    req_i = '0;

    // Fairness: all requesters continuously requesting for 9 transactions.
    do_reset();
    for (int k = 0; k < NR; k++) set_req(k, 1'b0, 32'(k * 16), 32'h0, 4'hf);
    for (int t = 0; t < 9; t++) begin
      tick();
      check($sformatf("fair_owner%0d", t), 64'(owner_o), 64'(t % 3));
      mem_gnt = 1'b1;
      mem_rsp_valid = 1'b1;
      settle();
      check($sformatf("fair_gnt%0d", t), 64'(gnt_o), 64'(1 << (t % 3)));
      for (int k = 0; k < NR; k++) if (gnt_o[k]) grants[k]++;
      tick();
      mem_gnt = 1'b0;
      mem_rsp_valid = 1'b0;
    end
    req_i = '0;
    for (int k = 0; k < NR; k++) check($sformatf("fair_count%0d", k), 64'(grants[k]), 64'd3);

    // Split response for requester 1 (last winner is 2, so 1 is found scanning from 0).
    set_req(1, 1'b0, 32'h0000_1000, 32'h0, 4'hf);
    tick();
    tick();
    mem_gnt = 1'b1;
    settle();
    check("split_gnt", 64'(gnt_o), 64'b010);
    check("split_rsp_n", 64'(rsp_valid_o), 64'd0);
    tick();
    mem_gnt = 1'b0;
    req_i[1] = 1'b0;
    settle();
    check("split_req_n1", 64'(mem_req), 64'd0);
    check("split_busy_n1", 64'(busy_o), 64'd1);
    check("split_rsp_n1", 64'(rsp_valid_o), 64'd0);
    tick();
    check("split_rsp_n2", 64'(rsp_valid_o), 64'd0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hdead_beef;
    settle();
    check("split_rsp_n3", 64'(rsp_valid_o), 64'b010);
    check("split_rdata", 64'(rdata_o), 64'hdead_beef);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check("split_done", 64'(busy_o), 64'd0);
    check("split_rsp_after", 64'(rsp_valid_o), 64'd0);

    // Back-to-back: requester 1 re-raises req in its own response cycle.
    set_req(1, 1'b0, 32'h0000_1004, 32'h0, 4'hf);
    tick();
    mem_gnt = 1'b1;
    settle();
    check("b2b_gnt", 64'(gnt_o), 64'b010);
    tick();
    mem_gnt = 1'b0;
    req_i[1] = 1'b0;
    tick();
    mem_rsp_valid = 1'b1;
    req_i[1] = 1'b1;
    settle();
    check("b2b_rsp", 64'(rsp_valid_o), 64'b010);
    check("b2b_req_m", 64'(mem_req), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check("b2b_req_m1", 64'(mem_req), 64'd0);
    check("b2b_busy_m1", 64'(busy_o), 64'd0);
    tick();
    check("b2b_req_m2", 64'(mem_req), 64'd1);
    check("b2b_owner", 64'(owner_o), 64'd1);
    mem_gnt = 1'b1;
    mem_rsp_valid = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rsp_valid = 1'b0;
    req_i = '0;

    // Reset while in WAIT_RSP; late response must be dropped; arbitration restarts at 0.
    set_req(2, 1'b0, 32'h0000_2000, 32'h0, 4'hf);
    tick();
    check("rmid_owner", 64'(owner_o), 64'd2);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    req_i = '0;
    settle();
    check("rmid_wait", 64'(busy_o), 64'd1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    mem_rsp_valid = 1'b1;
    settle();
    check("rmid_rsp", 64'(rsp_valid_o), 64'd0);
    check("rmid_busy", 64'(busy_o), 64'd0);
    check("rmid_req", 64'(mem_req), 64'd0);
    check("rmid_gnt", 64'(gnt_o), 64'd0);
    check("rmid_owner_rst", 64'(owner_o), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    check("rmid_rsp_next", 64'(rsp_valid_o), 64'd0);
    set_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'hf);
    set_req(2, 1'b0, 32'h0000_2000, 32'h0, 4'hf);
    tick();
    check("rmid_next_owner", 64'(owner_o), 64'd0);
    mem_gnt = 1'b1;
    mem_rsp_valid = 1'b1;
    settle();
    check("rmid_next_gnt", 64'(gnt_o), 64'b001);
    tick();
    mem_gnt = 1'b0;
    mem_rsp_valid = 1'b0;
    req_i = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
